// File: rtl/npc_pkg.sv
// npc_pkg: shared control-select encoding for the next-PC unit.
// Contents: npc_cs_t (3-bit control select) and its CS_* encodings.
// Imported by npc_unit; no logic of its own.
package npc_pkg;

  typedef logic [2:0] npc_cs_t;

  localparam npc_cs_t CS_SEQ  = 3'b000;  // pc + 1
  localparam npc_cs_t CS_BNE  = 3'b001;  // imm16 if !zero
  localparam npc_cs_t CS_J    = 3'b010;  // imm26
  localparam npc_cs_t CS_JR   = 3'b011;  // ra
  localparam npc_cs_t CS_CALL = 3'b100;  // imm26, push return address
  localparam npc_cs_t CS_BEQ  = 3'b101;  // imm16 if zero
  localparam npc_cs_t CS_RET  = 3'b110;  // RAS top (ra if empty), pop
  localparam npc_cs_t CS_HOLD = 3'b111;  // npc = pc

endpackage

// File: rtl/npc_ras.sv
// npc_ras: circular return-address stack; a push when full drops the oldest entry.
// Ports: clk/rst, push/pop strobes (already qualified by stall), din = return address,
//        top = newest entry (combinational), empty, ovf (sticky until reset).
module npc_ras #(
  parameter int AW        = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic          empty,
  output logic          ovf
);

  localparam int         PW   = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [AW-1:0] mem [RAS_DEPTH];
  logic [PW-1:0] wp;
  logic [PW:0]   cnt;

  // The newest entry sits just below the write pointer; the pointer wraps
  // naturally because RAS_DEPTH is a power of two.
  assign top   = mem[wp - PW'(1)];
  assign empty = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (push) begin
      wp <= wp + PW'(1);
      // When full, the write lands on the oldest slot: count stays saturated.
      if (cnt == FULL) ovf <= 1'b1;
      else             cnt <= cnt + (PW+1)'(1);
    end else if (pop && !empty) begin
      wp  <= wp - PW'(1);
      cnt <= cnt - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

endmodule

// File: rtl/npc_unit.sv
// npc_unit: architectural PC register and next-PC select for the fetch stage.
// Ports: clk/rst, stall (holds PC and RAS), cs/zero/imm/ra select inputs;
//        pc (registered), npc/taken (combinational), ras_empty, ras_ovf (sticky).
// Build option: define NPC_RAS_EN to include the return-address stack; without it
// call does not push, ret jumps to ra, ras_empty reads 1 and ras_ovf reads 0.
module npc_unit
  import npc_pkg::*;
#(
  parameter int            AW        = 32,
  parameter int            RAS_DEPTH = 8,
  parameter logic [AW-1:0] RESET_PC  = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic [2:0]    cs,
  input  logic          zero,
  input  logic [25:0]   imm,
  input  logic [AW-1:0] ra,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] npc,
  output logic          taken,
  output logic          ras_empty,
  output logic          ras_ovf
);

  // Immediate fields are zero-extended, or truncated when AW is narrower.
  localparam int N16 = (AW < 16) ? AW : 16;
  localparam int N26 = (AW < 26) ? AW : 26;

  npc_cs_t       sel;
  logic [AW-1:0] seq;
  logic [AW-1:0] imm16_ext;
  logic [AW-1:0] imm26_ext;
  logic [AW-1:0] ret_tgt;

  assign sel = npc_cs_t'(cs);
  assign seq = pc + AW'(1);

  always_comb begin
    imm16_ext = '0;
    imm26_ext = '0;
    for (int i = 0; i < N16; i++) imm16_ext[i] = imm[i];
    for (int i = 0; i < N26; i++) imm26_ext[i] = imm[i];
  end

`ifdef NPC_RAS_EN
  logic [AW-1:0] ras_top;
  logic          ras_push;
  logic          ras_pop;

  // Stack updates commit on the same edge as the PC, so stall gates them too.
  assign ras_push = !stall && (sel == CS_CALL);
  assign ras_pop  = !stall && (sel == CS_RET);

  npc_ras #(
    .AW        (AW),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (seq),
    .top   (ras_top),
    .empty (ras_empty),
    .ovf   (ras_ovf)
  );

  assign ret_tgt = ras_empty ? ra : ras_top;
`else
  assign ras_empty = 1'b1;
  assign ras_ovf   = 1'b0;
  assign ret_tgt   = ra;
`endif

  always_comb begin
    npc = seq;
    case (sel)
      CS_SEQ:  npc = seq;
      CS_BNE:  npc = zero ? seq : imm16_ext;
      CS_BEQ:  npc = zero ? imm16_ext : seq;
      CS_J:    npc = imm26_ext;
      CS_JR:   npc = ra;
      CS_CALL: npc = imm26_ext;
      CS_RET:  npc = ret_tgt;
      CS_HOLD: npc = pc;
      default: npc = seq;
    endcase
  end

  // Taken means "not the fall-through address", whatever source produced it.
  assign taken = (npc != seq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pc <= RESET_PC;
    else if (!stall) pc <= npc;
  end

endmodule

// File: tb/tb_npc_unit.sv
// tb_npc_unit: directed and random stimulus against a queue-based reference model.
// Two instances share the inputs: a 32-bit one (RESET_PC 0x100) and an 8-bit one
// (RESET_PC 0xF0) that exercises truncation and PC wrap. Both use a 4-entry RAS.
module tb_npc_unit;

`ifdef NPC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [2:0]  cs;
  logic        zero;
  logic [25:0] imm;
  logic [31:0] ra;

  logic [31:0] pc_a, npc_a;
  logic        taken_a, emp_a, ovf_a;
  logic [7:0]  pc_b, npc_b;
  logic        taken_b, emp_b, ovf_b;

  npc_unit #(.AW(32), .RAS_DEPTH(DEPTH), .RESET_PC(32'h100)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .cs(cs), .zero(zero), .imm(imm), .ra(ra),
    .pc(pc_a), .npc(npc_a), .taken(taken_a), .ras_empty(emp_a), .ras_ovf(ovf_a)
  );

  npc_unit #(.AW(8), .RAS_DEPTH(DEPTH), .RESET_PC(8'hF0)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .cs(cs), .zero(zero), .imm(imm), .ra(ra[7:0]),
    .pc(pc_b), .npc(npc_b), .taken(taken_b), .ras_empty(emp_b), .ras_ovf(ovf_b)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: PC per instance, RAS as a LIFO list (newest at the back).
  logic [31:0] m_pc_a, m_pc_b;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  bit          m_ovf_a, m_ovf_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Next PC from the instruction semantics, using the current inputs.
  function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [31:0] mask,
                                            input bit has_top, input logic [31:0] top);
    logic [31:0] s, i16, i26;
    s   = (p + 32'd1) & mask;
    i16 = {16'b0, imm[15:0]} & mask;
    i26 = {6'b0, imm} & mask;
    case (cs)
      3'b000:  return s;
      3'b001:  return zero ? s : i16;
      3'b101:  return zero ? i16 : s;
      3'b010:  return i26;
      3'b011:  return ra & mask;
      3'b100:  return i26;
      3'b110:  return (RAS_ON && has_top) ? top : (ra & mask);
      default: return p;
    endcase
  endfunction

  task automatic check_state(input string where);
    chk({where, ":pc_a"},  pc_a, m_pc_a);
    chk({where, ":pc_b"},  32'(pc_b), m_pc_b);
    chk({where, ":emp_a"}, 32'(emp_a), 32'(RAS_ON ? (qa.size() == 0) : 1'b1));
    chk({where, ":emp_b"}, 32'(emp_b), 32'(RAS_ON ? (qb.size() == 0) : 1'b1));
    chk({where, ":ovf_a"}, 32'(ovf_a), 32'(m_ovf_a));
    chk({where, ":ovf_b"}, 32'(ovf_b), 32'(m_ovf_b));
  endtask

  // Entered at a falling edge; returns at the next falling edge.
  task automatic step(input logic [2:0] c, input bit z, input logic [25:0] im,
                      input logic [31:0] r, input bit st);
    logic [31:0] ena, enb, sa, sb, ta, tb;
    cs = c; zero = z; imm = im; ra = r; stall = st;
    #1;
    ta = (qa.size() != 0) ? qa[qa.size()-1] : 32'h0;
    tb = (qb.size() != 0) ? qb[qb.size()-1] : 32'h0;
    ena = model_npc(m_pc_a, 32'hFFFF_FFFF, qa.size() != 0, ta);
    enb = model_npc(m_pc_b, 32'h0000_00FF, qb.size() != 0, tb);
    sa  = m_pc_a + 32'd1;
    sb  = (m_pc_b + 32'd1) & 32'hFF;
    chk("npc_a",   npc_a, ena);
    chk("taken_a", 32'(taken_a), 32'(ena != sa));
    chk("npc_b",   32'(npc_b), enb);
    chk("taken_b", 32'(taken_b), 32'(enb != sb));
    @(posedge clk);
    #1;
    if (!st) begin
      m_pc_a = ena;
      m_pc_b = enb;
      if (RAS_ON && c == 3'b100) begin
        if (qa.size() == DEPTH) begin qa.delete(0); m_ovf_a = 1'b1; end
        qa.push_back(sa);
        if (qb.size() == DEPTH) begin qb.delete(0); m_ovf_b = 1'b1; end
        qb.push_back(sb);
      end else if (RAS_ON && c == 3'b110) begin
        if (qa.size() != 0) qa.delete(qa.size()-1);
        if (qb.size() != 0) qb.delete(qb.size()-1);
      end
    end
    check_state("post_edge");
    @(negedge clk);
  endtask

  // Asynchronous reset raised between edges, held across one rising edge.
  task automatic rst_pulse();
    #2;
    rst = 1'b1;
    #1;
    m_pc_a = 32'h100; m_pc_b = 32'hF0;
    qa.delete(); qb.delete();
    m_ovf_a = 1'b0; m_ovf_b = 1'b0;
    chk("rst_pc_a_lit", pc_a, 32'h100);
    check_state("reset");
    chk("rst_npc_a", npc_a, model_npc(m_pc_a, 32'hFFFF_FFFF, 1'b0, 32'h0));
    @(negedge clk);
    check_state("reset_held");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; cs = 3'b000; zero = 1'b0; imm = '0; ra = '0;
    @(negedge clk);
    rst_pulse();

    // Sequential fetch after reset
    step(3'b000, 0, 26'h0, 32'h0, 0);
    chk("seq1_lit", pc_a, 32'h101);
    step(3'b000, 0, 26'h0, 32'h0, 0);
    chk("seq2_lit", pc_a, 32'h102);

    // Branches at pc=0x10, evaluated while stalled so pc stays put
    step(3'b010, 0, 26'h10, 32'h0, 0);
    step(3'b001, 0, 26'h40, 32'h0, 1);
    chk("bne_nz_npc", npc_a, 32'h40);
    chk("bne_nz_tk", 32'(taken_a), 32'h1);
    step(3'b001, 1, 26'h40, 32'h0, 1);
    chk("bne_z_npc", npc_a, 32'h11);
    chk("bne_z_tk", 32'(taken_a), 32'h0);
    step(3'b101, 1, 26'h40, 32'h0, 1);
    step(3'b101, 0, 26'h40, 32'h0, 1);
    step(3'b001, 0, 26'h11, 32'h0, 1);  // target equals fall-through
    step(3'b011, 0, 26'h0, 32'h1234_5678, 1);

    // Nested call/ret
    step(3'b010, 0, 26'h20, 32'h0, 0);
    step(3'b100, 0, 26'h80, 32'h0, 0);
    step(3'b100, 0, 26'h90, 32'h0, 0);
    step(3'b110, 0, 26'h0, 32'h0, 0);
    chk("ret1_lit", pc_a, RAS_ON ? 32'h81 : 32'h0);
    step(3'b110, 0, 26'h0, 32'h0, 0);
    chk("ret2_lit", pc_a, RAS_ON ? 32'h21 : 32'h0);
    step(3'b110, 0, 26'h0, 32'h55, 0);
    chk("ret3_lit", pc_a, 32'h55);

    // Overflow: one more call than entries, then drain
    for (int i = 0; i < DEPTH + 1; i++) step(3'b100, 0, 26'(32'h200 + i * 16), 32'h0, 0);
    chk("ovf_lit", 32'(ovf_a), 32'(RAS_ON));
    for (int i = 0; i < DEPTH; i++) step(3'b110, 0, 26'h0, 32'h0, 0);
    chk("ovf_last_lit", pc_a, RAS_ON ? 32'h201 : 32'h0);
    step(3'b110, 0, 26'h0, 32'h77, 0);
    chk("ovf_empty_lit", pc_a, 32'h77);

    // Stalled call: nothing commits until release, then exactly one push
    for (int i = 0; i < 3; i++) begin
      step(3'b100, 0, 26'h300, 32'h0, 1);
      chk("stall_npc_lit", npc_a, 32'h300);
    end
    step(3'b100, 0, 26'h300, 32'h0, 0);
    step(3'b110, 0, 26'h0, 32'h0, 0);
    chk("stall_ret_lit", pc_a, RAS_ON ? 32'h78 : 32'h0);

    // Wrap on the 8-bit instance, then hold
    step(3'b010, 0, 26'hFF, 32'h0, 0);
    step(3'b000, 0, 26'h0, 32'h0, 0);
    chk("wrap_b_lit", 32'(pc_b), 32'h0);
    chk("wrap_a_lit", pc_a, 32'h100);
    step(3'b111, 0, 26'h0, 32'h0, 0);

    // Reset while stalled, then ret on an empty stack falls back to ra
    step(3'b100, 0, 26'h44, 32'h0, 0);
    step(3'b100, 0, 26'h48, 32'h0, 1);
    stall = 1'b1;
    rst_pulse();
    step(3'b110, 0, 26'h0, 32'h33, 0);
    chk("ret_ra_lit", pc_a, 32'h33);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) rst_pulse();
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 26'($urandom),
           $urandom, $urandom_range(0, 4) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
